// File: rtl/usb3_tx_arbiter.sv
// usb3_tx_arbiter
// Round-robin packet scheduler in front of the FT601 245 TX wrapper.
// Each grant sends one header word {A5, channel, seq, len} and then
// len data words popped from the granted first-word-fall-through FIFO.
// A burst pauses for backpressure or an empty source, but it is never
// abandoned except by reset.

module usb3_tx_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int MAX_BURST = 256,
    parameter int LVL_W     = 16
) (
    input  logic                     sys_clk_i,
    input  logic                     rst_i,
    input  logic [NUM_CH-1:0]        ch_enable_i,
    input  logic [NUM_CH-1:0]        ch_empty_i,
    input  logic [NUM_CH*LVL_W-1:0]  ch_level_i,
    input  logic [NUM_CH*32-1:0]     ch_dout_i,
    output logic [NUM_CH-1:0]        ch_rd_en_o,
    output logic                     tx_en_o,
    output logic [31:0]              tx_din_o,
    input  logic                     tx_prog_full_i,
    output logic                     busy_o,
    output logic [3:0]               grant_o
);

    // Channel vectors are padded to 16 entries so the 4-bit grant index
    // can address them directly for any NUM_CH in 2..16.
    localparam int          SLOTS   = 16;
    localparam logic [15:0] MAX_LEN = 16'(MAX_BURST);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]  state_reg;
    logic [3:0]  grant_reg;
    logic [15:0] len_reg;
    logic [15:0] word_cnt_reg;
    logic [3:0]  rr_ptr_reg;
    logic        tx_en_reg;
    logic [31:0] tx_din_reg;
    logic [3:0]  seq_reg [SLOTS];

    logic [SLOTS-1:0] elig_vec;
    logic [SLOTS-1:0] empty_vec;
    logic [15:0]      cap_vec  [SLOTS];
    logic [31:0]      word_vec [SLOTS];

    logic        pick_valid;
    logic [3:0]  pick_idx;
    logic        hdr_fire;
    logic        pop;
    logic [3:0]  rr_next;
    logic [31:0] hdr_word;

    genvar gi;

    // Per-channel decode: eligibility, burst length cap and head word.
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < NUM_CH) begin : g_live
                logic [31:0] lvl32;
                assign lvl32          = 32'(ch_level_i[gi*LVL_W +: LVL_W]);
                assign elig_vec[gi]   = ch_enable_i[gi] && !ch_empty_i[gi] && (lvl32 != 32'd0);
                assign empty_vec[gi]  = ch_empty_i[gi];
                assign cap_vec[gi]    = (lvl32 > 32'(MAX_BURST)) ? MAX_LEN : lvl32[15:0];
                assign word_vec[gi]   = ch_dout_i[gi*32 +: 32];
            end else begin : g_pad
                assign elig_vec[gi]   = 1'b0;
                assign empty_vec[gi]  = 1'b1;
                assign cap_vec[gi]    = 16'd0;
                assign word_vec[gi]   = 32'd0;
            end
        end
    endgenerate

    // Rotating priority scan: the smallest offset from rr_ptr wins, so the
    // loop runs from the far end and lets nearer hits overwrite.
    always_comb begin
        logic [4:0] scan_idx;
        pick_valid = 1'b0;
        pick_idx   = 4'd0;
        for (int off = NUM_CH - 1; off >= 0; off--) begin
            scan_idx = {1'b0, rr_ptr_reg} + 5'(off);
            if (scan_idx >= 5'(NUM_CH)) begin
                scan_idx = scan_idx - 5'(NUM_CH);
            end
            if (elig_vec[scan_idx[3:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx[3:0];
            end
        end
    end

    // Transfer qualifiers for the header and data phases.
    always_comb begin
        hdr_fire = (state_reg == ST_HDR) && !tx_prog_full_i;
        pop      = (state_reg == ST_DATA) && !tx_prog_full_i &&
                   !empty_vec[grant_reg] && !rst_i;
        rr_next  = (grant_reg == 4'(NUM_CH - 1)) ? 4'd0 : grant_reg + 4'd1;
        hdr_word = {8'hA5, grant_reg, seq_reg[grant_reg], len_reg};
    end

    // Pop strobe goes only to the granted channel, in the same cycle.
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_rd
            assign ch_rd_en_o[gi] = pop && (grant_reg == 4'(gi));
        end
    endgenerate

    // Scheduler state machine and registered TX outputs.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= 4'd0;
            len_reg      <= 16'd0;
            word_cnt_reg <= 16'd0;
            rr_ptr_reg   <= 4'd0;
            tx_en_reg    <= 1'b0;
            tx_din_reg   <= 32'd0;
        end else begin
            tx_en_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_reg <= pick_idx;
                        len_reg   <= cap_vec[pick_idx];
                        state_reg <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (hdr_fire) begin
                        tx_en_reg    <= 1'b1;
                        tx_din_reg   <= hdr_word;
                        word_cnt_reg <= len_reg;
                        state_reg    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (pop) begin
                        tx_en_reg    <= 1'b1;
                        tx_din_reg   <= word_vec[grant_reg];
                        word_cnt_reg <= word_cnt_reg - 16'd1;
                        if (word_cnt_reg == 16'd1) begin
                            state_reg  <= ST_IDLE;
                            rr_ptr_reg <= rr_next;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-channel 4-bit packet sequence numbers, bumped as each header goes out.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SLOTS; i++) begin
                seq_reg[i] <= 4'd0;
            end
        end else if (hdr_fire) begin
            seq_reg[grant_reg] <= seq_reg[grant_reg] + 4'd1;
        end
    end

    assign tx_en_o  = tx_en_reg;
    assign tx_din_o = tx_din_reg;
    assign busy_o   = (state_reg != ST_IDLE);
    assign grant_o  = grant_reg;

endmodule

// File: tb/tb_usb3_tx_arbiter.sv
// Testbench for usb3_tx_arbiter: behavioural FWFT source FIFOs feed the
// arbiter, a monitor records every tx_en_o word, and a packet-level model
// predicts the full TX stream from the FIFO contents and enables.
`timescale 1ns/1ps

module tb_usb3_tx_arbiter;

    localparam int NUM_CH    = 4;
    localparam int MAX_BURST = 256;
    localparam int LVL_W     = 16;

    logic                    clk;
    logic                    rst;
    logic [NUM_CH-1:0]       ch_enable;
    logic [NUM_CH-1:0]       ch_empty;
    logic [NUM_CH*LVL_W-1:0] ch_level;
    logic [NUM_CH*32-1:0]    ch_dout;
    logic [NUM_CH-1:0]       ch_rd_en;
    logic                    tx_en;
    logic [31:0]             tx_din;
    logic                    tx_prog_full;
    logic                    busy;
    logic [3:0]              grant;

    usb3_tx_arbiter #(
        .NUM_CH   (NUM_CH),
        .MAX_BURST(MAX_BURST),
        .LVL_W    (LVL_W)
    ) dut (
        .sys_clk_i     (clk),
        .rst_i         (rst),
        .ch_enable_i   (ch_enable),
        .ch_empty_i    (ch_empty),
        .ch_level_i    (ch_level),
        .ch_dout_i     (ch_dout),
        .ch_rd_en_o    (ch_rd_en),
        .tx_en_o       (tx_en),
        .tx_din_o      (tx_din),
        .tx_prog_full_i(tx_prog_full),
        .busy_o        (busy),
        .grant_o       (grant)
    );

    logic [31:0] fifo_q [NUM_CH][$];
    logic [31:0] obs_q[$];
    int          obs_t[$];
    logic [31:0] exp_q[$];
    logic [3:0]  model_seq [NUM_CH];
    int          model_rr;
    int          pop_count [NUM_CH];
    int          bad_pop;
    int          onehot_viol;
    int          cyc;
    int          checks;
    int          errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic refresh();
        for (int k = 0; k < NUM_CH; k++) begin
            ch_empty[k]                = (fifo_q[k].size() == 0);
            ch_level[k*LVL_W +: LVL_W] = LVL_W'(fifo_q[k].size());
            ch_dout[k*32 +: 32]        = (fifo_q[k].size() > 0) ? fifo_q[k][0] : 32'hDEAD_BEEF;
        end
    endtask

    // FWFT source FIFOs: sample the pop strobes mid-cycle, apply after the edge.
    initial begin
        logic [NUM_CH-1:0] pend;
        bad_pop     = 0;
        onehot_viol = 0;
        for (int k = 0; k < NUM_CH; k++) pop_count[k] = 0;
        refresh();
        forever begin
            @(negedge clk);
            #2;
            pend = ch_rd_en;
            if ($countones(pend) > 1) onehot_viol++;
            @(posedge clk);
            #1;
            for (int k = 0; k < NUM_CH; k++) begin
                if (pend[k]) begin
                    if (fifo_q[k].size() > 0) begin
                        void'(fifo_q[k].pop_front());
                        pop_count[k]++;
                    end else begin
                        bad_pop++;
                    end
                end
            end
            refresh();
        end
    end

    // TX monitor: every word the wrapper would accept, with its cycle stamp.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_en === 1'b1) begin
                obs_q.push_back(tx_din);
                obs_t.push_back(cyc);
            end
        end
    end

    // Packet-level reference: rotate over enabled non-empty channels,
    // each packet = header + min(count, MAX_BURST) words in FIFO order.
    task automatic build_expected(input logic [NUM_CH-1:0] en);
        int cnt [NUM_CH];
        int idx [NUM_CH];
        int pick;
        int len;
        int c;
        for (int k = 0; k < NUM_CH; k++) begin
            cnt[k] = fifo_q[k].size();
            idx[k] = 0;
        end
        pick = 0;
        while (pick >= 0) begin
            pick = -1;
            for (int o = NUM_CH - 1; o >= 0; o--) begin
                c = (model_rr + o) % NUM_CH;
                if (en[c] && cnt[c] > 0) pick = c;
            end
            if (pick >= 0) begin
                len = (cnt[pick] > MAX_BURST) ? MAX_BURST : cnt[pick];
                exp_q.push_back({8'hA5, 4'(pick), model_seq[pick], 16'(len)});
                model_seq[pick] = model_seq[pick] + 4'd1;
                for (int i = 0; i < len; i++) exp_q.push_back(fifo_q[pick][idx[pick] + i]);
                idx[pick] += len;
                cnt[pick] -= len;
                model_rr = (pick + 1) % NUM_CH;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) model_seq[k] = 4'd0;
        model_rr = 0;
    endtask

    task automatic start_scenario();
        obs_q.delete();
        obs_t.delete();
        exp_q.delete();
    endtask

    function automatic logic [31:0] obs_at(input int i);
        return (i < obs_q.size()) ? obs_q[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic bit work_left();
        return ((ch_enable & ~ch_empty) != '0);
    endfunction

    task automatic push_random(input int ch, input int n);
        for (int i = 0; i < n; i++) fifo_q[ch].push_back($urandom);
    endtask

    // Run until the arbiter has been quiet for several cycles with nothing left.
    task automatic drain(input int max_cycles, input bit rand_pf, input string name);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 4 && n < max_cycles) begin
            @(negedge clk);
            n++;
            if (rand_pf) tx_prog_full = ($urandom_range(0, 3) == 0);
            if (!busy && !tx_en && !work_left()) quiet++;
            else quiet = 0;
        end
        tx_prog_full = 1'b0;
        checks++;
        if (quiet < 4) begin
            errors++;
            $display("FAIL %s_drain: still busy after %0d cycles, busy=%0b", name, n, busy);
        end
    endtask

    task automatic compare_stream(input string name);
        int n;
        int shown;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_length: got %0d words, expected %0d", name, obs_q.size(), exp_q.size());
        end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        shown = 0;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                if (shown < 8) begin
                    $display("FAIL %s_word[%0d]: got %08h expected %08h", name, i, obs_q[i], exp_q[i]);
                    shown++;
                end
            end
        end
        $display("%s: %0d words observed, %0d expected", name, obs_q.size(), exp_q.size());
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        tx_prog_full = 1'b0;
        ch_enable    = '0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b expected 0", tx_en); end
        checks++;
        if (tx_din !== 32'd0) begin errors++; $display("FAIL reset_tx_din: got %08h expected 00000000", tx_din); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (grant !== 4'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant); end
        checks++;
        if (ch_rd_en !== '0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", ch_rd_en); end
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_single_packet();
        int c;
        int p0;
        start_scenario();
        ch_enable = '1;
        fifo_q[2].push_back(32'h11);
        fifo_q[2].push_back(32'h22);
        fifo_q[2].push_back(32'h33);
        build_expected(ch_enable);
        p0 = pop_count[2];
        @(posedge clk);
        #2;
        c = cyc;
        drain(200, 1'b0, "single");
        compare_stream("single");
        checks++;
        if (obs_at(0) !== 32'hA520_0003) begin errors++; $display("FAIL single_header: got %08h expected A5200003", obs_at(0)); end
        checks++;
        if (obs_t.size() < 4 || obs_t[0] != c + 2) begin
            errors++;
            $display("FAIL single_latency: header at cycle %0d expected %0d", (obs_t.size() > 0) ? obs_t[0] : -1, c + 2);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (obs_t.size() < 4 || obs_t[i] != obs_t[0] + i) begin
                errors++;
                $display("FAIL single_consecutive[%0d]: words not on consecutive cycles", i);
            end
        end
        checks++;
        if (pop_count[2] - p0 != 3) begin errors++; $display("FAIL single_pops: got %0d expected 3", pop_count[2] - p0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        start_scenario();
        ch_enable = 4'b0011;
        push_random(0, 600);
        push_random(1, 600);
        build_expected(ch_enable);
        drain(5000, 1'b0, "round_robin");
        compare_stream("round_robin");
        checks++;
        if (obs_at(0) !== 32'hA500_0100) begin errors++; $display("FAIL rr_hdr0: got %08h expected A5000100", obs_at(0)); end
        checks++;
        if (obs_at(257) !== 32'hA510_0100) begin errors++; $display("FAIL rr_hdr1: got %08h expected A5100100", obs_at(257)); end
        checks++;
        if (obs_at(514) !== 32'hA501_0100) begin errors++; $display("FAIL rr_hdr2: got %08h expected A5010100", obs_at(514)); end
        checks++;
        if (obs_at(1028) !== 32'hA502_0058) begin errors++; $display("FAIL rr_hdr4: got %08h expected A5020058", obs_at(1028)); end
    endtask

    task automatic test_backpressure();
        int n;
        start_scenario();
        ch_enable = 4'b0001;
        push_random(0, 300);
        build_expected(ch_enable);
        n = 0;
        while (obs_q.size() < 100 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (obs_q.size() < 100) begin errors++; $display("FAIL bp_start: got %0d words expected >= 100", obs_q.size()); end
        tx_prog_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #3;
            checks++;
            if (ch_rd_en !== '0) begin errors++; $display("FAIL bp_rd_en[%0d]: got %b expected 0", i, ch_rd_en); end
            @(negedge clk);
            if (i >= 1) begin
                checks++;
                if (tx_en !== 1'b0) begin errors++; $display("FAIL bp_tx_en[%0d]: got %b expected 0", i, tx_en); end
            end
        end
        tx_prog_full = 1'b0;
        drain(3000, 1'b0, "backpressure");
        compare_stream("backpressure");
    endtask

    task automatic test_underflow();
        logic [31:0] held [3];
        int p3;
        int p0;
        int n;
        start_scenario();
        ch_enable = 4'b1001;
        push_random(3, 8);
        push_random(0, 4);
        build_expected(ch_enable);
        p3 = pop_count[3];
        n = 0;
        while (busy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (grant !== 4'd3) begin errors++; $display("FAIL uf_grant: got %0d expected 3", grant); end
        for (int i = 2; i >= 0; i--) held[i] = fifo_q[3].pop_back();
        n = 0;
        while (pop_count[3] - p3 < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        p0 = pop_count[0];
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || grant !== 4'd3 || pop_count[0] != p0) begin
                errors++;
                $display("FAIL uf_stall[%0d]: busy=%b grant=%0d ch0_pops=%0d expected busy=1 grant=3 ch0_pops=%0d",
                         i, busy, grant, pop_count[0], p0);
            end
            if (i >= 1) begin
                checks++;
                if (tx_en !== 1'b0) begin errors++; $display("FAIL uf_tx_en[%0d]: got %b expected 0", i, tx_en); end
            end
        end
        for (int i = 0; i < 3; i++) fifo_q[3].push_back(held[i]);
        drain(500, 1'b0, "underflow");
        compare_stream("underflow");
    endtask

    task automatic test_seq_wrap();
        logic [31:0] h;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        start_scenario();
        ch_enable = 4'b0001;
        for (int p = 0; p < 17; p++) begin
            push_random(0, 1);
            build_expected(ch_enable);
            drain(100, 1'b0, "seq_wrap");
        end
        compare_stream("seq_wrap");
        for (int p = 0; p < 17; p++) begin
            h = obs_at(2 * p);
            checks++;
            if (h !== {8'hA5, 4'd0, 4'(p % 16), 16'd1}) begin
                errors++;
                $display("FAIL seq_wrap_hdr[%0d]: got %08h expected seq %0d", p, h, p % 16);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            start_scenario();
            ch_enable = 4'($urandom_range(1, 15));
            for (int k = 0; k < NUM_CH; k++) push_random(k, $urandom_range(0, 300));
            build_expected(ch_enable);
            drain(20000, 1'b1, "random");
            compare_stream("random");
            checks++;
            if (onehot_viol != 0 || bad_pop != 0) begin
                errors++;
                $display("FAIL random_pops: onehot_viol=%0d bad_pop=%0d expected 0/0", onehot_viol, bad_pop);
            end
            for (int k = 0; k < NUM_CH; k++) fifo_q[k].delete();
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int q0;
        start_scenario();
        ch_enable = 4'b0011;
        push_random(0, 300);
        n = 0;
        while (obs_q.size() < 20 && n < 500) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        q0 = fifo_q[0].size();
        #1;
        checks++;
        if (ch_rd_en !== '0) begin errors++; $display("FAIL rstmid_rd_en: got %b expected 0", ch_rd_en); end
        @(negedge clk);
        checks++;
        if (tx_en !== 1'b0 || tx_din !== 32'd0 || busy !== 1'b0 || grant !== 4'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: tx_en=%b tx_din=%08h busy=%b grant=%0d expected all 0", tx_en, tx_din, busy, grant);
        end
        checks++;
        if (fifo_q[0].size() != q0) begin errors++; $display("FAIL rstmid_pop: got %0d left expected %0d", fifo_q[0].size(), q0); end
        fifo_q[0].delete();
        start_scenario();
        model_reset();
        push_random(1, 1);
        build_expected(ch_enable);
        @(posedge clk);
        #2;
        @(negedge clk);
        rst = 1'b0;
        drain(100, 1'b0, "reset_mid");
        compare_stream("reset_mid");
        checks++;
        if (obs_at(0) !== 32'hA510_0001) begin errors++; $display("FAIL rstmid_header: got %08h expected A5100001", obs_at(0)); end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        tx_prog_full = 1'b0;
        ch_enable    = '0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_underflow();
        test_seq_wrap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
